// File: rtl/reg_file_multich.sv
// GPO/GPI command register file with log-memory reader and per-channel BER snapshot.
// Optional REGFILE_AUTO_INC_EN adds READ_NEXT (auto-incrementing memory read).
module reg_file_multich #(
  parameter int NB_ADDR_MEM = 15,
  parameter int N_CH        = 2,
  parameter int NB_BER      = 64,
  parameter int MEM_RD_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_gpo,
  input  logic [31:0]              i_data_log_from_mem,
  input  logic                     i_mem_full,
  input  logic [N_CH*NB_BER-1:0]   i_ber_samp,
  input  logic [N_CH*NB_BER-1:0]   i_ber_error,
  output logic [31:0]              o_gpi,
  output logic                     o_rst,
  output logic                     o_enbTx,
  output logic                     o_enbRx,
  output logic [1:0]               o_phase_sel,
  output logic                     o_run_log,
  output logic                     o_read_log,
  output logic [NB_ADDR_MEM-1:0]   o_addr_log_to_mem
);

  localparam int NW = (NB_BER + 31) / 32;
  localparam logic [3:0] LAST = 4'(MEM_RD_LAT - 1);

  localparam logic [7:0] C_RST       = 8'd0;
  localparam logic [7:0] C_EN_TX     = 8'd1;
  localparam logic [7:0] C_EN_RX     = 8'd2;
  localparam logic [7:0] C_PH_SEL    = 8'd3;
  localparam logic [7:0] C_RUN_MEM   = 8'd4;
  localparam logic [7:0] C_READ_MEM  = 8'd5;
  localparam logic [7:0] C_BER_SNAP  = 8'd6;
  localparam logic [7:0] C_BER_WORD  = 8'd7;
  localparam logic [7:0] C_MEM_FULL  = 8'd8;
  localparam logic [7:0] C_STATUS    = 8'd9;

  typedef enum logic {IDLE, READ} state_t;

  state_t                   state_q, state_d;
  logic                     en_prev;
  logic                     err;
  logic [3:0]               cnt_q;
  logic [NW*32-1:0]         snap_q;

  logic [7:0]               cmd;
  logic [22:0]              d;
  logic                     acc;
  logic                     idle_acc;
  logic                     is_rd;
  logic                     is_rd_next;
  logic [NB_ADDR_MEM-1:0]   rd_addr;
  logic                     ch_ok;
  logic [NB_BER-1:0]        ber_sel;
  logic [NW*32-1:0]         ber_ext;
  logic [31:0]              word_sel;
  logic                     rd_start;
  logic                     rd_done;
  logic                     err_set;
  logic                     status_clr;
  logic                     unused_bits;

  assign cmd         = i_gpo[31:24];
  assign d           = i_gpo[22:0];
  assign acc         = i_gpo[23] & ~en_prev;
  assign idle_acc    = acc & (state_q == IDLE);
  assign unused_bits = ^d;
  assign o_read_log  = (state_q == READ);

`ifdef REGFILE_AUTO_INC_EN
  localparam logic [7:0] C_READ_NEXT = 8'd10;
  assign is_rd_next = (cmd == C_READ_NEXT);
  assign rd_addr    = is_rd_next ?
                      o_addr_log_to_mem + NB_ADDR_MEM'(1) :
                      d[NB_ADDR_MEM-1:0];
`else
  assign is_rd_next = 1'b0;
  assign rd_addr    = d[NB_ADDR_MEM-1:0];
`endif

  assign is_rd      = (cmd == C_READ_MEM) | is_rd_next;
  assign ch_ok      = int'(d[7:0]) < N_CH;
  assign status_clr = idle_acc & (cmd == C_STATUS);

  always_comb begin
    ber_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (d[7:0] == 8'(k)) begin
        ber_sel = d[8] ? i_ber_error[k*NB_BER +: NB_BER]
                       : i_ber_samp[k*NB_BER +: NB_BER];
      end
    end
    ber_ext = '0;
    ber_ext[NB_BER-1:0] = ber_sel;
  end

  // out-of-range word index falls through to zero
  always_comb begin
    word_sel = '0;
    for (int w = 0; w < NW; w++) begin
      if (d[7:0] == 8'(w)) word_sel = snap_q[w*32 +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_start = 1'b0;
    rd_done  = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (is_rd) begin
            if (i_mem_full) begin
              state_d  = READ;
              rd_start = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end else if (cmd == C_BER_SNAP && !ch_ok) begin
            err_set = 1'b1;
          end
        end
      end
      READ: begin
        if (acc) err_set = 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          rd_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q           <= IDLE;
      en_prev           <= 1'b0;
      err               <= 1'b0;
      cnt_q             <= '0;
      snap_q            <= '0;
      o_gpi             <= '0;
      o_rst             <= 1'b0;
      o_enbTx           <= 1'b0;
      o_enbRx           <= 1'b0;
      o_phase_sel       <= '0;
      o_run_log         <= 1'b0;
      o_addr_log_to_mem <= '0;
    end else begin
      en_prev   <= i_gpo[23];
      state_q   <= state_d;
      o_run_log <= 1'b0;
      // a new error in the same cycle beats the STATUS clear
      err       <= err_set | (err & ~status_clr);
      if (rd_start) begin
        cnt_q             <= '0;
        o_addr_log_to_mem <= rd_addr;
      end else if (state_q == READ) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (rd_done) o_gpi <= i_data_log_from_mem;
      if (idle_acc) begin
        unique case (1'b1)
          (cmd == C_RST):     o_rst       <= d[0];
          (cmd == C_EN_TX):   o_enbTx     <= d[0];
          (cmd == C_EN_RX):   o_enbRx     <= d[0];
          (cmd == C_PH_SEL):  o_phase_sel <= d[1:0];
          (cmd == C_RUN_MEM): o_run_log   <= 1'b1;
          (cmd == C_BER_SNAP): begin
            if (ch_ok) begin
              snap_q <= ber_ext;
              o_gpi  <= ber_ext[31:0];
            end else begin
              snap_q <= '0;
              o_gpi  <= '0;
            end
          end
          (cmd == C_BER_WORD): o_gpi <= word_sel;
          (cmd == C_MEM_FULL): o_gpi <= {31'b0, i_mem_full};
          (cmd == C_STATUS):
            o_gpi <= {28'b0, err, i_mem_full, o_enbRx, o_enbTx};
          default: ;
        endcase
      end
    end
  end

endmodule
